uart_bus_peripheral: RTL and testbench

//  Memory-mapped UART responder behind memory_controller's decode of UART_TX_ADDR/UART_RX_ADDR/UART_TX_DONE/UART_RX_DONE.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/uart_bit_timer.sv | 33 +++
 rtl/uart_bus_peripheral.sv | 203 ++++++++++++++++++++
 tb/tb_uart_bus_peripheral.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Memory-map constants and UART state encodings shared by the bus peripherals.
// The UART_PARITY_EN build option (see uart_bus_peripheral) adds the PARITY states to the frames.
package mem_pkg;

    localparam logic [31:0] UART_TX_ADDR = 32'h8000_0000;
    localparam logic [31:0] UART_RX_ADDR = 32'h8000_0004;
    localparam logic [31:0] UART_TX_DONE = 32'h8000_0008;
    localparam logic [31:0] UART_RX_DONE = 32'h8000_000C;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } UART_TX_STATE_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } UART_RX_STATE_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: load arms a full or half bit count, tick pulses at the end
// of each period and the counter reloads a full bit automatically while run is high.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic load,
    input  logic half,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] cnt;

    assign tick = run && !load && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst || (!run && !load))
            cnt <= '0;
        else if (load)
            cnt <= half ? HALF : FULL;
        else if (cnt == '0)
            cnt <= FULL;
        else
            cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/uart_bus_peripheral.sv
// Memory-mapped full-duplex UART (8N1) with combinational read data.
// Define UART_PARITY_EN to add an even parity bit on TX and a parity check on RX.
module uart_bus_peripheral
    import mem_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wrdata,
    input  logic        bus_wren,
    output logic [31:0] bus_rddata,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

`ifdef UART_PARITY_EN
    localparam UART_TX_STATE_t TX_AFTER_DATA = TX_PARITY;
    localparam UART_RX_STATE_t RX_AFTER_DATA = RX_PARITY;
`else
    localparam UART_TX_STATE_t TX_AFTER_DATA = TX_STOP;
    localparam UART_RX_STATE_t RX_AFTER_DATA = RX_STOP;
`endif

    UART_TX_STATE_t tx_state, tx_next;
    UART_RX_STATE_t rx_state, rx_next;

    logic       tx_line, tx_done, tx_load, tx_tick;
    logic [7:0] tx_byte, tx_shift;
    logic [2:0] tx_idx;
    logic       rx_s1, rx_s2, rx_s3, rx_fall;
    logic       rx_load, rx_half, rx_tick;
    logic       rx_done, parity_err;
    logic [7:0] rx_data, rx_shift;
    logic [2:0] rx_idx;
    logic       tx_wr, rx_clr;
    logic       unused_wrdata;

    assign unused_wrdata = ^bus_wrdata[31:8];
    assign tx_wr   = bus_wren && (bus_addr == UART_TX_ADDR) && tx_done;
    assign rx_clr  = bus_wren && (bus_addr == UART_RX_DONE);
    assign rx_fall = rx_s3 && !rx_s2;
    assign uart_tx = tx_line;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (tx_state != TX_IDLE),
        .load (tx_load),
        .half (1'b0),
        .tick (tx_tick)
    );

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (rx_state != RX_IDLE),
        .load (rx_load),
        .half (rx_half),
        .tick (rx_tick)
    );

    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        unique case (tx_state)
            TX_IDLE: if (tx_wr) begin
                tx_next = TX_START;
                tx_load = 1'b1;
            end
            TX_START:  if (tx_tick) tx_next = TX_DATA;
            TX_DATA:   if (tx_tick && tx_idx == 3'd7) tx_next = TX_AFTER_DATA;
            TX_PARITY: if (tx_tick) tx_next = TX_STOP;
            TX_STOP:   if (tx_tick) tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_line  <= 1'b1;
            tx_done  <= 1'b1;
            tx_byte  <= '0;
            tx_shift <= '0;
            tx_idx   <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_wr) begin
                tx_byte  <= bus_wrdata[7:0];
                tx_shift <= bus_wrdata[7:0];
                tx_done  <= 1'b0;
                tx_line  <= 1'b0;
                tx_idx   <= '0;
            end else if (tx_tick) begin
                unique case (tx_state)
                    TX_START: tx_line <= tx_shift[0];
                    TX_DATA: begin
                        tx_shift <= tx_shift >> 1;
                        tx_idx   <= tx_idx + 3'd1;
`ifdef UART_PARITY_EN
                        tx_line  <= (tx_idx == 3'd7) ? ^tx_byte : tx_shift[1];
`else
                        tx_line  <= (tx_idx == 3'd7) ? 1'b1 : tx_shift[1];
`endif
                    end
                    TX_PARITY: tx_line <= 1'b1;
                    TX_STOP:   tx_done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Start detection resamples at half a bit so DATA/STOP samples land mid-bit.
    always_comb begin
        rx_next = rx_state;
        rx_load = 1'b0;
        rx_half = 1'b0;
        unique case (rx_state)
            RX_IDLE: if (rx_fall) begin
                rx_next = RX_START;
                rx_load = 1'b1;
                rx_half = 1'b1;
            end
            RX_START:  if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_tick && rx_idx == 3'd7) rx_next = RX_AFTER_DATA;
            RX_PARITY: if (rx_tick) rx_next = RX_STOP;
            RX_STOP:   if (rx_tick) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

`ifdef UART_PARITY_EN
    logic rx_par;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_done  <= 1'b0;
            rx_data  <= '0;
            rx_shift <= '0;
            rx_idx   <= '0;
`ifdef UART_PARITY_EN
            rx_par     <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_state <= rx_next;
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            if (rx_clr) begin
                rx_done <= 1'b0;
`ifdef UART_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
            // Completion is applied after the clear so it wins on the same edge.
            if (rx_tick) begin
                unique case (rx_state)
                    RX_DATA: begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_idx   <= rx_idx + 3'd1;
                    end
`ifdef UART_PARITY_EN
                    RX_PARITY: rx_par <= rx_s2;
`endif
                    RX_STOP: if (rx_s2) begin
                        rx_data <= rx_shift;
                        rx_done <= 1'b1;
`ifdef UART_PARITY_EN
                        parity_err <= rx_par ^ (^rx_shift);
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus_rddata = '0;
        unique case (1'b1)
            bus_addr == UART_TX_ADDR: bus_rddata = {24'b0, tx_byte};
            bus_addr == UART_RX_ADDR: bus_rddata = {24'b0, rx_data};
            bus_addr == UART_TX_DONE: bus_rddata = {31'b0, tx_done};
            bus_addr == UART_RX_DONE: bus_rddata = {30'b0, parity_err, rx_done};
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_bus_peripheral.sv
// Directed bench for uart_bus_peripheral at 10 clocks per bit.
// Frame length and expected flags follow UART_PARITY_EN when it is defined.
module tb_uart_bus_peripheral;
    import mem_pkg::*;

`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wrdata = '0;
    logic        bus_wren = 1'b0;
    logic [31:0] bus_rddata;
    logic        rx_drive = 1'b1;
    logic        loop = 1'b0;
    logic        uart_tx;
    logic        rx_line;

    int vectors = 0;
    int errors  = 0;

    assign rx_line = loop ? uart_tx : rx_drive;

    always #5 clk = ~clk;

    uart_bus_peripheral #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_addr   (bus_addr),
        .bus_wrdata (bus_wrdata),
        .bus_wren   (bus_wren),
        .bus_rddata (bus_rddata),
        .uart_rx    (rx_line),
        .uart_tx    (uart_tx)
    );

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus_addr = a;
        #1;
        d = bus_rddata;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus_addr   = a;
        bus_wrdata = d;
        bus_wren   = 1'b1;
        @(posedge clk);
        #1;
        bus_wren = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input logic badpar);
        @(posedge clk);
        #1;
        rx_drive = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_drive = b[i];
            repeat (10) @(posedge clk);
            #1;
        end
`ifdef UART_PARITY_EN
        rx_drive = (^b) ^ badpar;
        repeat (10) @(posedge clk);
        #1;
`else
        if (badpar) rx_drive = 1'b1;
`endif
        rx_drive = stop;
        repeat (10) @(posedge clk);
        #1;
        rx_drive = 1'b1;
    endtask

    // Samples each bit mid-period; optionally writes 0x3C to TX mid-frame.
    task automatic check_tx_frame(input logic [7:0] b, input bit inject);
        logic [10:0] bits;
        logic [31:0] d;
`ifdef UART_PARITY_EN
        bits = {1'b1, ^b, b, 1'b0};
`else
        bits = {1'b0, 1'b1, b, 1'b0};
`endif
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < NB; i++) begin
            vectors++;
            if (uart_tx !== bits[i]) begin
                errors++;
                $display("FAIL tx_bit%0d byte=%h: got %b want %b", i, b, uart_tx, bits[i]);
            end
            if (i == NB - 1) begin
                repeat (4) @(posedge clk);
                #1;
                rd(UART_TX_DONE, d);
                vectors++;
                if (d !== 32'd0) begin
                    errors++;
                    $display("FAIL tx_done_early: got %h want 0", d);
                end
                @(posedge clk);
                #1;
                rd(UART_TX_DONE, d);
                vectors++;
                if (d !== 32'd1) begin
                    errors++;
                    $display("FAIL tx_done_end: got %h want 1", d);
                end
            end else if (inject && i == 3) begin
                bus_addr   = UART_TX_ADDR;
                bus_wrdata = 32'h3C;
                bus_wren   = 1'b1;
                @(posedge clk);
                #1;
                bus_wren = 1'b0;
                repeat (9) @(posedge clk);
                #1;
            end else begin
                repeat (10) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx_line: got %b want 1", uart_tx);
        end
        rd(UART_TX_DONE, d);
        vectors++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL reset_tx_done: got %h want 1", d);
        end
        rd(UART_RX_DONE, d);
        vectors++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_rx_done: got %h want 0", d);
        end
        @(posedge clk);
        #1;
        rd(UART_RX_ADDR, d);
        vectors++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_rx_data: got %h want 0", d);
        end
        rd(UART_TX_ADDR, d);
        vectors++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_tx_byte: got %h want 0", d);
        end
        rd(32'h0000_1234, d);
        vectors++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL unmapped_read: got %h want 0", d);
        end
    endtask

    task automatic test_tx();
        logic [31:0] d;
        bus_write(UART_TX_ADDR, 32'hFFFF_FFA5);
        vectors++;
        if (uart_tx !== 1'b0) begin
            errors++;
            $display("FAIL tx_start_edge: got %b want 0", uart_tx);
        end
        rd(UART_TX_DONE, d);
        vectors++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL tx_done_clear: got %h want 0", d);
        end
        rd(UART_TX_ADDR, d);
        vectors++;
        if (d !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL tx_byte_read: got %h want a5", d);
        end
        check_tx_frame(8'hA5, 1'b0);
    endtask

    task automatic test_tx_busy();
        logic [31:0] d;
        bus_write(UART_TX_ADDR, 32'hA5);
        check_tx_frame(8'hA5, 1'b1);
        rd(UART_TX_ADDR, d);
        vectors++;
        if (d !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL tx_busy_byte: got %h want a5", d);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL tx_busy_idle: got %b want 1", uart_tx);
        end
    endtask

    task automatic test_rx();
        logic [31:0] d;
        send_rx(8'h5A, 1'b1, 1'b0);
        rd(UART_RX_DONE, d);
        vectors++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL rx_done: got %h want 1", d);
        end
        rd(UART_RX_ADDR, d);
        vectors++;
        if (d !== 32'h5A) begin
            errors++;
            $display("FAIL rx_data: got %h want 5a", d);
        end
        bus_write(UART_RX_DONE, 32'h0);
        rd(UART_RX_DONE, d);
        vectors++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rx_clear: got %h want 0", d);
        end
        rd(UART_RX_ADDR, d);
        vectors++;
        if (d !== 32'h5A) begin
            errors++;
            $display("FAIL rx_data_kept: got %h want 5a", d);
        end
    endtask

    task automatic test_rx_errors();
        logic [31:0] d;
        @(posedge clk);
        #1;
        rx_drive = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_drive = 1'b1;
        repeat (120) @(posedge clk);
        #1;
        rd(UART_RX_DONE, d);
        vectors++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rx_glitch: got %h want 0", d);
        end
        send_rx(8'h33, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rd(UART_RX_DONE, d);
        vectors++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rx_framing_done: got %h want 0", d);
        end
        rd(UART_RX_ADDR, d);
        vectors++;
        if (d !== 32'h5A) begin
            errors++;
            $display("FAIL rx_framing_data: got %h want 5a", d);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        send_rx(8'h11, 1'b1, 1'b0);
        send_rx(8'h22, 1'b1, 1'b0);
        rd(UART_RX_DONE, d);
        vectors++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL overrun_done: got %h want 1", d);
        end
        rd(UART_RX_ADDR, d);
        vectors++;
        if (d !== 32'h22) begin
            errors++;
            $display("FAIL overrun_data: got %h want 22", d);
        end
        bus_write(UART_RX_DONE, 32'h1);
    endtask

    task automatic test_loopback(input logic [7:0] b);
        logic [31:0] d;
        loop = 1'b1;
        bus_write(UART_TX_ADDR, {24'h0, b});
        repeat (10 * NB + 10) @(posedge clk);
        #1;
        rd(UART_RX_DONE, d);
        vectors++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL loop_done byte=%h: got %h want 1", b, d);
        end
        rd(UART_RX_ADDR, d);
        vectors++;
        if (d !== {24'h0, b}) begin
            errors++;
            $display("FAIL loop_data: got %h want %h", d, b);
        end
        loop = 1'b0;
        bus_write(UART_RX_DONE, 32'h0);
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        logic [31:0] d;
        bus_write(UART_TX_ADDR, 32'h07);
        check_tx_frame(8'h07, 1'b0);
        send_rx(8'h07, 1'b1, 1'b1);
        rd(UART_RX_DONE, d);
        vectors++;
        if (d !== 32'd3) begin
            errors++;
            $display("FAIL parity_err: got %h want 3", d);
        end
        rd(UART_RX_ADDR, d);
        vectors++;
        if (d !== 32'h07) begin
            errors++;
            $display("FAIL parity_data: got %h want 07", d);
        end
        bus_write(UART_RX_DONE, 32'h0);
    endtask
`endif

    task automatic test_reset_midframe();
        logic [31:0] d;
        bus_write(UART_TX_ADDR, 32'h00);
        repeat (15) @(posedge clk);
        #1;
        vectors++;
        if (uart_tx !== 1'b0) begin
            errors++;
            $display("FAIL midframe_low: got %b want 0", uart_tx);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL midframe_line: got %b want 1", uart_tx);
        end
        rd(UART_TX_DONE, d);
        vectors++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL midframe_done: got %h want 1", d);
        end
        rd(UART_TX_ADDR, d);
        vectors++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL midframe_byte: got %h want 0", d);
        end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_tx_busy();
        test_rx();
        test_rx_errors();
        test_overrun();
        test_loopback(8'hC3);
        test_loopback(8'h07);
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
